cpu_fsm_controller: RTL and testbench

- Multi-cycle control unit for the 16-bit CR16-style datapath.
- Holds PC, IR and the PSR flag register {Z,C,F,N,L}.
- Sequences fetch, decode, execute, memory and writeback; drives the ALU opcode, register-file strobes and memory strobes.
- Evaluates branch conditions against the latched PSR; sits between unified memory, regfile and ALU.

---
 rtl/cpu_pkg.sv | 120 ++++++++++++
 rtl/cpu_fsm_controller_if.sv | 33 +++
 rtl/cpu_fsm_controller_branch_cond_eval.sv | 29 ++
 rtl/cpu_fsm_controller.sv | 146 ++++++++++++++
 tb/tb_cpu_fsm_controller.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the CR16-style controller: ALU opcodes, flag indices, op/ext/cond codes, FSM states.
// ALU_* values are the single source of truth for the ALU and the controller.
package cpu_pkg;

    localparam logic [4:0] ALU_NOP  = 5'h00;
    localparam logic [4:0] ALU_AND  = 5'h01;
    localparam logic [4:0] ALU_OR   = 5'h02;
    localparam logic [4:0] ALU_XOR  = 5'h03;
    localparam logic [4:0] ALU_ADD  = 5'h05;
    localparam logic [4:0] ALU_ADDU = 5'h06;
    localparam logic [4:0] ALU_SUB  = 5'h09;
    localparam logic [4:0] ALU_CMP  = 5'h0B;
    localparam logic [4:0] ALU_MOV  = 5'h0D;
    localparam logic [4:0] ALU_CMPU = 5'h0F;

    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_L = 0;

    localparam logic [3:0] OP_RR    = 4'b0000;
    localparam logic [3:0] OP_LDST  = 4'b0100;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_ADDU = 4'b0110;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_CMPU = 4'b1111;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FC = 4'b1100;
    localparam logic [3:0] COND_FS = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_LOADWB
    } state_e;

    typedef enum logic [2:0] {
        K_ALU,
        K_BR,
        K_LOAD,
        K_STOR,
        K_ILL
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        logic [4:0] alu_op;
        logic       imm_op;
        logic       rf_write;
        logic       psr_write;
        logic       imm_signed;
    } dec_t;

    function automatic logic [4:0] alu_code(input logic [3:0] code);
        logic [4:0] r;
        case (code)
            EXT_AND:  r = ALU_AND;
            EXT_OR:   r = ALU_OR;
            EXT_XOR:  r = ALU_XOR;
            EXT_ADD:  r = ALU_ADD;
            EXT_ADDU: r = ALU_ADDU;
            EXT_SUB:  r = ALU_SUB;
            EXT_CMP:  r = ALU_CMP;
            EXT_MOV:  r = ALU_MOV;
            EXT_CMPU: r = ALU_CMPU;
            default:  r = ALU_NOP;
        endcase
        return r;
    endfunction

    // Register forms carry the ALU code in ext; immediate forms reuse the same code in op.
    function automatic dec_t decode(input logic [15:0] ir);
        dec_t       d;
        logic [3:0] op;
        logic [3:0] code;
        logic [4:0] a;
        op   = ir[15:12];
        code = (op == OP_RR) ? ir[7:4] : op;
        a    = alu_code(code);
        d    = '{kind: K_ILL, alu_op: ALU_NOP, imm_op: 1'b0, rf_write: 1'b0,
                 psr_write: 1'b0, imm_signed: 1'b0};
        if (op == OP_BCOND) begin
            d.kind = K_BR;
        end else if (op == OP_LDST) begin
            if (ir[7:4] == EXT_LOAD)      d.kind = K_LOAD;
            else if (ir[7:4] == EXT_STOR) d.kind = K_STOR;
        end else if (a != ALU_NOP) begin
            d.kind       = K_ALU;
            d.alu_op     = a;
            d.imm_op     = (op != OP_RR);
            d.rf_write   = (a != ALU_CMP) && (a != ALU_CMPU);
            d.psr_write  = (a == ALU_ADD) || (a == ALU_ADDU) || (a == ALU_SUB) ||
                           (a == ALU_CMP) || (a == ALU_CMPU);
            d.imm_signed = (a == ALU_ADD) || (a == ALU_SUB) || (a == ALU_CMP) || (a == ALU_MOV);
        end
        return d;
    endfunction

endpackage

// File: rtl/cpu_fsm_controller_if.sv
// Controller <-> datapath/memory bundle; master is the controller side, slave the datapath/memory side.
interface cpu_fsm_controller_if #(parameter int DATA_W = 16);
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [4:0]        alu_flags;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic              mem_addr_sel;
    logic              mem_en;
    logic              mem_we;
    logic [4:0]        alu_opcode;
    logic              imm_sel;
    logic [DATA_W-1:0] imm;
    logic [3:0]        rf_raddr_a;
    logic [3:0]        rf_raddr_b;
    logic [3:0]        rf_waddr;
    logic              rf_wen;
    logic              wb_sel;
    logic [4:0]        psr;
    logic              illegal;

    modport master (
        input  mem_rdata, mem_ready, alu_flags,
        output pc, ir, mem_addr_sel, mem_en, mem_we, alu_opcode, imm_sel, imm,
               rf_raddr_a, rf_raddr_b, rf_waddr, rf_wen, wb_sel, psr, illegal
    );

    modport slave (
        output mem_rdata, mem_ready, alu_flags,
        input  pc, ir, mem_addr_sel, mem_en, mem_we, alu_opcode, imm_sel, imm,
               rf_raddr_a, rf_raddr_b, rf_waddr, rf_wen, wb_sel, psr, illegal
    );
endinterface

// File: rtl/cpu_fsm_controller_branch_cond_eval.sv
// Branch condition evaluator: cond code against latched PSR, purely combinational.
// Undefined codes and the explicit "never" code fall through to not-taken.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] psr,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken =  psr[FLAG_Z];
            COND_NE: taken = !psr[FLAG_Z];
            COND_CS: taken =  psr[FLAG_C];
            COND_CC: taken = !psr[FLAG_C];
            COND_HI: taken =  psr[FLAG_L];
            COND_LS: taken = !psr[FLAG_L];
            COND_GT: taken =  psr[FLAG_N];
            COND_LE: taken = !psr[FLAG_N];
            COND_FC: taken = !psr[FLAG_F];
            COND_FS: taken =  psr[FLAG_F];
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_fsm_controller.sv
// Multi-cycle CR16-style control unit: FETCH/DECODE/EXEC(/MEM/LOADWB); ALU+branch 3 cycles, STOR 4, LOAD 5.
// FETCH and MEM hold their requests until mem_ready; strobes are forced low while reset is asserted.
module cpu_fsm_controller
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    cpu_fsm_controller_if.master bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [4:0]        psr_q, psr_d;
    logic              illegal_q, illegal_d;

    dec_t              dec;
    logic              taken;
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] sext8;
    logic [DATA_W-1:0] zext8;

    logic              mem_en;
    logic              mem_we;
    logic              mem_addr_sel;
    logic              rf_wen;
    logic              wb_sel;
    logic [4:0]        alu_opcode;

    assign dec    = decode(ir_q);
    assign pc_inc = pc_q + DATA_W'(1);
    assign sext8  = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign zext8  = {{(DATA_W-8){1'b0}}, ir_q[7:0]};

    branch_cond_eval u_branch_cond_eval (
        .cond  (ir_q[11:8]),
        .psr   (psr_q),
        .taken (taken)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        psr_d        = psr_q;
        illegal_d    = illegal_q;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        rf_wen       = 1'b0;
        wb_sel       = 1'b0;
        alu_opcode   = ALU_NOP;

        case (state_q)
            ST_FETCH: begin
                mem_en = 1'b1;
                if (bus.mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = bus.mem_rdata;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (dec.kind)
                    K_ALU: begin
                        alu_opcode = dec.alu_op;
                        rf_wen     = dec.rf_write;
                        if (dec.psr_write) psr_d = bus.alu_flags;
                        pc_d = pc_inc;
                    end
                    K_BR:   pc_d = taken ? (pc_q + sext8) : pc_inc;
                    K_LOAD: state_d = ST_MEM;
                    K_STOR: state_d = ST_MEM;
                    default: begin
                        illegal_d = 1'b1;
                        pc_d      = pc_inc;
                    end
                endcase
            end
            ST_MEM: begin
                mem_en       = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (dec.kind == K_STOR);
                if (bus.mem_ready) begin
                    if (dec.kind == K_STOR) begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_LOADWB;
                    end
                end
            end
            ST_LOADWB: begin
                // Memory registers its output, so load data is still on mem_rdata here.
                rf_wen  = 1'b1;
                wb_sel  = 1'b1;
                pc_d    = pc_inc;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        if (!reset) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
            rf_wen = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            psr_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            psr_q     <= psr_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.ir           = ir_q;
    assign bus.psr          = psr_q;
    assign bus.illegal      = illegal_q;
    assign bus.mem_en       = mem_en;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr_sel = mem_addr_sel;
    assign bus.rf_wen       = rf_wen;
    assign bus.wb_sel       = wb_sel;
    assign bus.alu_opcode   = alu_opcode;
    assign bus.imm_sel      = dec.imm_op;
    assign bus.imm          = dec.imm_signed ? sext8 : zext8;
    assign bus.rf_raddr_a   = ir_q[11:8];
    assign bus.rf_raddr_b   = ir_q[3:0];
    assign bus.rf_waddr     = ir_q[11:8];

endmodule

// File: tb/tb_cpu_fsm_controller.sv
// Scoreboarded bench: driver plays memory and pushes per-instruction expectations; monitor slices the
// DUT activity into instruction windows (fetch to next fetch) and checks each against the queue.
module tb_cpu_fsm_controller;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    cpu_fsm_controller_if bus ();

    cpu_fsm_controller #(.DATA_W(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycles;
        int          rf_cnt;
        int          we_cnt;
        int          wb_cnt;
        int          mem_cnt;
        bit          is_alu;
        bit          exec_rf;
        logic [4:0]  alu_op;
        bit          imm_sel;
        logic [15:0] imm;
        logic [15:0] pc;
        logic [4:0]  psr;
        bit          ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_pc  = 16'h0000;
    logic [4:0]  m_psr = 5'b0;
    bit          m_ill = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [4:0] exp_alu(input logic [3:0] c);
        case (c)
            4'h1:    return ALU_AND;
            4'h2:    return ALU_OR;
            4'h3:    return ALU_XOR;
            4'h5:    return ALU_ADD;
            4'h6:    return ALU_ADDU;
            4'h9:    return ALU_SUB;
            4'hB:    return ALU_CMP;
            4'hD:    return ALU_MOV;
            4'hF:    return ALU_CMPU;
            default: return ALU_NOP;
        endcase
    endfunction

    function automatic bit cond_true(input logic [3:0] c, input logic [4:0] p);
        bit z, cf, f, n, l;
        {z, cf, f, n, l} = p;
        case (c)
            4'h0: return z;   4'h1: return !z;
            4'h2: return cf;  4'h3: return !cf;
            4'h4: return l;   4'h5: return !l;
            4'h6: return n;   4'h7: return !n;
            4'hC: return !f;  4'hD: return f;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Architectural effect of one instruction plus the cycle/strobe budget implied by the wait counts.
    task automatic model(input logic [15:0] ins, input logic [4:0] flags, input int fw, input int mw,
                         output bit is_mem);
        exp_t       e;
        logic [3:0] op, code;
        op   = ins[15:12];
        code = (op == 4'h0) ? ins[7:4] : op;
        e.cycles = fw + 3; e.rf_cnt = 0; e.we_cnt = 0; e.wb_cnt = 0; e.mem_cnt = 0;
        e.is_alu = 0; e.exec_rf = 0; e.alu_op = ALU_NOP; e.imm_sel = 0; e.imm = 16'h0;
        is_mem = 0;
        if (op == 4'hC) begin
            if (cond_true(ins[11:8], m_psr)) m_pc = m_pc + {{8{ins[7]}}, ins[7:0]};
            else                             m_pc = m_pc + 16'd1;
        end else if (op == 4'h4 && (ins[7:4] == 4'h0 || ins[7:4] == 4'h4)) begin
            is_mem    = 1;
            e.mem_cnt = mw + 1;
            e.cycles  = fw + 4 + mw;
            if (ins[7:4] == 4'h0) begin
                e.cycles += 1; e.rf_cnt = 1; e.wb_cnt = 1;
            end else begin
                e.we_cnt = mw + 1;
            end
            m_pc = m_pc + 16'd1;
        end else if (op != 4'h4 && code inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD, 4'hF}) begin
            e.is_alu  = 1;
            e.alu_op  = exp_alu(code);
            e.exec_rf = !(code inside {4'hB, 4'hF});
            e.rf_cnt  = e.exec_rf;
            e.imm_sel = (op != 4'h0);
            e.imm     = (code inside {4'h5, 4'h9, 4'hB, 4'hD}) ? {{8{ins[7]}}, ins[7:0]} : {8'h00, ins[7:0]};
            if (code inside {4'h5, 4'h6, 4'h9, 4'hB, 4'hF}) m_psr = flags;
            m_pc = m_pc + 16'd1;
        end else begin
            m_ill = 1;
            m_pc  = m_pc + 16'd1;
        end
        e.pc = m_pc; e.psr = m_psr; e.ill = m_ill;
        exp_q.push_back(e);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] c;
        int         k;
        k = $urandom_range(0, 10);
        case ($urandom_range(0, 8))
            0: c = 4'h1; 1: c = 4'h2; 2: c = 4'h3; 3: c = 4'h5; 4: c = 4'h6;
            5: c = 4'h9; 6: c = 4'hB; 7: c = 4'hD; default: c = 4'hF;
        endcase
        case (k)
            0, 1, 2: return {4'h0, 4'($urandom), c, 4'($urandom)};
            3, 4:    return {c, 4'($urandom), 8'($urandom)};
            5, 6:    return {4'hC, 4'($urandom), 8'($urandom)};
            7:       return {4'h4, 4'($urandom), 4'h0, 4'($urandom)};
            8:       return {4'h4, 4'($urandom), 4'h4, 4'($urandom)};
            9: begin
                case ($urandom_range(0, 3))
                    0: c = 4'h7; 1: c = 4'h8; 2: c = 4'hA; default: c = 4'hE;
                endcase
                return {c, 12'($urandom)};
            end
            default: return {4'h0, 4'($urandom), 4'h0, 4'($urandom)};
        endcase
    endfunction

    task automatic run_instr(input logic [15:0] ins, input logic [4:0] flags, input int fw, input int mw);
        bit is_mem;
        int n;
        n = 0;
        while (!(bus.mem_en && !bus.mem_addr_sel)) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
            if (n > 20) begin
                checks++; errors++;
                $display("FAIL fetch_wait: got no fetch expected fetch within 20 cycles");
                return;
            end
        end
        model(ins, flags, fw, mw, is_mem);
        bus.mem_rdata = ins;
        bus.alu_flags = flags;
        repeat (fw) begin bus.mem_ready = 1'b0; @(negedge clk); end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        if (is_mem) begin
            n = 0;
            while (!(bus.mem_en && bus.mem_addr_sel)) begin
                bus.mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
                if (n > 20) begin
                    checks++; errors++;
                    $display("FAIL mem_wait: got no mem access expected one within 20 cycles");
                    return;
                end
            end
            repeat (mw) begin bus.mem_ready = 1'b0; @(negedge clk); end
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0;
        end
    endtask

    // Monitor: one window per instruction, closed when the next fetch appears.
    bit          w_open, prev_f, cur_f;
    int          w_idx, cyc, post, rf_c, we_c, wb_c, mem_c, bad_c;
    logic [4:0]  s_op;
    bit          s_isel, s_rf;
    logic [15:0] s_imm;

    initial begin
        exp_t e;
        w_open = 0; prev_f = 0; w_idx = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                w_open = 0; prev_f = 0;
                continue;
            end
            cur_f = bus.mem_en && !bus.mem_addr_sel;
            if (cur_f && !prev_f) begin
                if (w_open) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL i%0d.sb: got completion expected empty queue", w_idx);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("i%0d.cycles", w_idx), cyc, e.cycles);
                        chk($sformatf("i%0d.rf_wen_cnt", w_idx), rf_c, e.rf_cnt);
                        chk($sformatf("i%0d.mem_we_cnt", w_idx), we_c, e.we_cnt);
                        chk($sformatf("i%0d.wb_sel_cnt", w_idx), wb_c, e.wb_cnt);
                        chk($sformatf("i%0d.mem_cycles", w_idx), mem_c, e.mem_cnt);
                        chk($sformatf("i%0d.strobe_excl", w_idx), bad_c, 0);
                        chk($sformatf("i%0d.pc", w_idx), bus.pc, e.pc);
                        chk($sformatf("i%0d.psr", w_idx), bus.psr, e.psr);
                        chk($sformatf("i%0d.illegal", w_idx), bus.illegal, e.ill);
                        if (e.is_alu) begin
                            chk($sformatf("i%0d.alu_opcode", w_idx), s_op, e.alu_op);
                            chk($sformatf("i%0d.exec_rf_wen", w_idx), s_rf, e.exec_rf);
                            chk($sformatf("i%0d.imm_sel", w_idx), s_isel, e.imm_sel);
                            if (e.imm_sel) chk($sformatf("i%0d.imm", w_idx), s_imm, e.imm);
                        end
                    end
                    w_idx++;
                end
                w_open = 1; cyc = 0; post = 0;
                rf_c = 0; we_c = 0; wb_c = 0; mem_c = 0; bad_c = 0;
            end
            if (w_open) begin
                cyc++;
                if (bus.rf_wen) rf_c++;
                if (bus.mem_we) we_c++;
                if (bus.wb_sel) wb_c++;
                if (bus.mem_en && bus.mem_addr_sel) mem_c++;
                if ((bus.rf_wen && bus.mem_we) || (bus.mem_we && !(bus.mem_en && bus.mem_addr_sel))) bad_c++;
                if (!cur_f) begin
                    post++;
                    if (post == 2) begin
                        s_op = bus.alu_opcode; s_isel = bus.imm_sel; s_imm = bus.imm; s_rf = bus.rf_wen;
                    end
                end
            end
            prev_f = cur_f;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b0;
        bus.mem_rdata = 16'h0;
        bus.mem_ready = 1'b1;
        bus.alu_flags = 5'h1F;
        repeat (3) @(negedge clk);
        chk("rst.pc", bus.pc, 16'h0000);
        chk("rst.ir", bus.ir, 16'h0000);
        chk("rst.psr", bus.psr, 5'b0);
        chk("rst.illegal", bus.illegal, 1'b0);
        chk("rst.strobes", {bus.mem_en, bus.mem_we, bus.rf_wen}, 3'b000);
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        run_instr(16'h01B2, 5'b00010, 0, 0);   // CMP: psr <= flags, no write
        run_instr(16'hC6FE, 5'b11111, 0, 0);   // BGT -2 from pc 1 -> FFFF
        run_instr(16'h0152, 5'b00000, 0, 0);   // ADD at FFFF wraps pc to 0000
        run_instr(16'h4102, 5'b10101, 0, 3);   // LOAD with three stall cycles in MEM
        run_instr(16'h4142, 5'b01010, 0, 0);   // STOR
        run_instr(16'h7000, 5'b11111, 1, 0);   // undecodable op
        run_instr(16'h0000, 5'b11111, 0, 0);   // RR with undefined ext
        run_instr(16'h5380, 5'b00100, 2, 0);   // ADD imm, negative
        run_instr(16'h6380, 5'b00001, 0, 0);   // ADDU imm, zero-extended
        for (int i = 0; i < 160; i++)
            run_instr(rand_instr(), 5'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));

        n = 0;
        while (!(bus.mem_en && !bus.mem_addr_sel) && n < 20) begin
            bus.mem_ready = 1'b0; @(negedge clk); n++;
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        @(negedge clk);
        chk("sb.drained", exp_q.size(), 0);

        bus.mem_rdata = 16'h4102;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        n = 0;
        while (!(bus.mem_en && bus.mem_addr_sel) && n < 20) begin @(negedge clk); n++; end
        chk("mid.mem_en", bus.mem_en, 1'b1);
        chk("mid.addr_sel", bus.mem_addr_sel, 1'b1);
        chk("mid.illegal_sticky", bus.illegal, 1'b1);
        repeat (2) @(negedge clk);
        chk("mid.hold", {bus.mem_en, bus.mem_addr_sel, bus.rf_wen}, 3'b110);
        reset = 1'b0;
        @(negedge clk);
        chk("mid.rst_pc", bus.pc, 16'h0000);
        chk("mid.rst_illegal", bus.illegal, 1'b0);
        chk("mid.rst_psr", bus.psr, 5'b0);
        chk("mid.rst_strobes", {bus.mem_en, bus.mem_we, bus.rf_wen}, 3'b000);
        reset = 1'b1;
        @(negedge clk);
        chk("mid.refetch", {bus.mem_en, bus.mem_addr_sel, bus.rf_wen}, 3'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
